// File: rtl/testcore_ipl_ram2p.sv
// testcore_ipl_ram2p: dual-port Avalon-MM on-chip RAM, byte-enabled writes, pipelined reads.
// Define TESTCORE_IPL_WRITE_LOCK_EN to build the sticky boot-region write lock.
module testcore_ipl_ram2p #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 11,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned LOCK_WORDS   = 512,
  parameter string       INIT_FILE    = "testcore_ipl_memory.hex"
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    clken,
  input  logic                    reset_req,
  input  logic [ADDR_WIDTH-1:0]   s1_address,
  input  logic                    s1_chipselect,
  input  logic                    s1_read,
  input  logic                    s1_write,
  input  logic [DATA_WIDTH/8-1:0] s1_byteenable,
  input  logic [DATA_WIDTH-1:0]   s1_writedata,
  output logic                    s1_waitrequest,
  output logic [DATA_WIDTH-1:0]   s1_readdata,
  output logic                    s1_readdatavalid,
  input  logic [ADDR_WIDTH-1:0]   s2_address,
  input  logic                    s2_chipselect,
  input  logic                    s2_read,
  input  logic                    s2_write,
  input  logic [DATA_WIDTH/8-1:0] s2_byteenable,
  input  logic [DATA_WIDTH-1:0]   s2_writedata,
  output logic                    s2_waitrequest,
  output logic [DATA_WIDTH-1:0]   s2_readdata,
  output logic                    s2_readdatavalid,
  input  logic                    lock_set,
  output logic                    locked
);

  localparam int unsigned NumBytes = DATA_WIDTH / 8;
  localparam int unsigned Depth    = 1 << ADDR_WIDTH;

  // Preload from INIT_FILE is applied by the implementation flow, not by this RTL.
  if (INIT_FILE == "") begin : g_no_preload
  end

  logic [DATA_WIDTH-1:0] mem_q [Depth];

  logic [1:0][ADDR_WIDTH-1:0] addr;
  logic [1:0][NumBytes-1:0]   be;
  logic [1:0][DATA_WIDTH-1:0] wdata;
  logic [1:0]                 cs, rd, wr;
  logic [1:0]                 wr_acc, rd_acc, wr_en, lock_hit;
  logic                       waitreq;
  logic                       lock_active;

  assign addr  = {s2_address, s1_address};
  assign be    = {s2_byteenable, s1_byteenable};
  assign wdata = {s2_writedata, s1_writedata};
  assign cs    = {s2_chipselect, s1_chipselect};
  assign rd    = {s2_read, s1_read};
  assign wr    = {s2_write, s1_write};

  assign waitreq        = ~clken | reset_req;
  assign s1_waitrequest = waitreq;
  assign s2_waitrequest = waitreq;

`ifdef TESTCORE_IPL_WRITE_LOCK_EN
  logic locked_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      locked_q <= 1'b0;
    end else if (clken && lock_set) begin
      locked_q <= 1'b1;
    end
  end
  assign lock_active = locked_q;
`else
  logic unused_lock_set;
  assign unused_lock_set = lock_set;
  assign lock_active     = 1'b0;
`endif
  assign locked = lock_active;

  always_comb begin
    wr_acc   = '0;
    rd_acc   = '0;
    lock_hit = '0;
    wr_en    = '0;
    for (int p = 0; p < 2; p++) begin
      wr_acc[p]   = cs[p] & wr[p] & ~waitreq;
      // A simultaneous write wins; the read half of the command is dropped.
      rd_acc[p]   = cs[p] & rd[p] & ~wr[p] & ~waitreq;
      lock_hit[p] = lock_active && (32'(addr[p]) < LOCK_WORDS);
    end
    wr_en[0] = wr_acc[0] & ~lock_hit[0];
    wr_en[1] = wr_acc[1] & ~lock_hit[1] & ~(wr_acc[0] && (addr[0] == addr[1]));
  end

  always_ff @(posedge clk) begin
    for (int p = 0; p < 2; p++) begin
      if (wr_en[p]) begin
        for (int b = 0; b < int'(NumBytes); b++) begin
          if (be[p][b]) mem_q[addr[p]][b*8 +: 8] <= wdata[p][b*8 +: 8];
        end
      end
    end
  end

  // First read stage samples the array before this edge's writes land (old-data semantics).
  logic [1:0]                 v1_q;
  logic [1:0][DATA_WIDTH-1:0] d1_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1_q <= '0;
      d1_q <= '0;
    end else begin
      if (reset_req) begin
        v1_q <= '0;
      end else if (clken) begin
        v1_q <= rd_acc;
      end
      for (int p = 0; p < 2; p++) begin
        if (rd_acc[p]) d1_q[p] <= mem_q[addr[p]];
      end
    end
  end

  logic [1:0]                 out_valid;
  logic [1:0][DATA_WIDTH-1:0] out_data;

  if (READ_LATENCY == 2) begin : g_lat2
    logic [1:0]                 v2_q;
    logic [1:0][DATA_WIDTH-1:0] d2_q;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        v2_q <= '0;
        d2_q <= '0;
      end else if (reset_req) begin
        v2_q <= '0;
      end else if (clken) begin
        v2_q <= v1_q;
        for (int p = 0; p < 2; p++) begin
          if (v1_q[p]) d2_q[p] <= d1_q[p];
        end
      end
    end

    assign out_valid = v2_q;
    assign out_data  = d2_q;
  end else begin : g_lat1
    assign out_valid = v1_q;
    assign out_data  = d1_q;
  end

  // Stalled or flushed cycles never present a valid beat.
  assign s1_readdatavalid = out_valid[0] & ~waitreq;
  assign s2_readdatavalid = out_valid[1] & ~waitreq;
  assign s1_readdata      = out_data[0];
  assign s2_readdata      = out_data[1];

endmodule

// File: tb/tb_testcore_ipl_ram2p.sv
// Bench for testcore_ipl_ram2p: latency-1 and latency-2 instances share stimulus and are
// checked every cycle against a memory-plus-pending-reads model, with literal spot checks.
module tb_testcore_ipl_ram2p;

  localparam int unsigned Dw = 32;
  localparam int unsigned Aw = 11;
`ifdef TESTCORE_IPL_WRITE_LOCK_EN
  localparam bit LockEn = 1'b1;
`else
  localparam bit LockEn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          clken = 1'b1;
  logic          reset_req = 1'b0;
  logic          lock_set = 1'b0;
  logic [1:0]    cs = '0, rd = '0, wr = '0;
  logic [Aw-1:0] addr [2];
  logic [3:0]    be [2];
  logic [Dw-1:0] wd [2];

  wire [1:0]    o_wt [2];
  wire [1:0]    o_v  [2];
  wire [Dw-1:0] o_d  [2][2];
  wire          o_lk [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    testcore_ipl_ram2p #(.READ_LATENCY(g + 1)) u_dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .clken            (clken),
      .reset_req        (reset_req),
      .s1_address       (addr[0]),
      .s1_chipselect    (cs[0]),
      .s1_read          (rd[0]),
      .s1_write         (wr[0]),
      .s1_byteenable    (be[0]),
      .s1_writedata     (wd[0]),
      .s1_waitrequest   (o_wt[g][0]),
      .s1_readdata      (o_d[g][0]),
      .s1_readdatavalid (o_v[g][0]),
      .s2_address       (addr[1]),
      .s2_chipselect    (cs[1]),
      .s2_read          (rd[1]),
      .s2_write         (wr[1]),
      .s2_byteenable    (be[1]),
      .s2_writedata     (wd[1]),
      .s2_waitrequest   (o_wt[g][1]),
      .s2_readdata      (o_d[g][1]),
      .s2_readdatavalid (o_v[g][1]),
      .lock_set         (lock_set),
      .locked           (o_lk[g])
    );
  end

  // Model: known memory words plus, per instance/port, the reads still owed and their age
  // counted in enabled clocks.
  typedef struct packed {
    logic [31:0] data;
    logic        known;
    logic [7:0]  age;
  } pend_t;

  pend_t         pq [4][$];
  logic [31:0]   ref_mem [int];
  bit            m_locked = 1'b0;
  int            vcnt [2][2];
  logic [31:0]   last_d [2][2];
  int            vlow = 0;
  bit            burst_log = 1'b0;
  logic [31:0]   burst_q [$];
  int            n_cmp = 0;
  int            n_bad = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic mem_write(input logic [Aw-1:0] a, input logic [3:0] b, input logic [31:0] d);
    int          key;
    logic [31:0] v;
    key = int'(a);
    if (ref_mem.exists(key)) begin
      v = ref_mem[key];
      for (int i = 0; i < 4; i++) if (b[i]) v[i*8 +: 8] = d[i*8 +: 8];
      ref_mem[key] = v;
    end else if (b == 4'hF) begin
      ref_mem[key] = d;
    end
  endtask

  task automatic model_edge();
    logic       wt;
    logic [1:0] wacc, racc, wen;
    pend_t      e;
    int         p, lat, key;
    wt = !clken || reset_req;
    for (int i = 0; i < 2; i++) begin
      wacc[i] = cs[i] && wr[i] && !wt;
      racc[i] = cs[i] && rd[i] && !wr[i] && !wt;
      wen[i]  = wacc[i] && !(m_locked && int'(addr[i]) < 512);
    end
    if (wacc[0] && wacc[1] && addr[0] == addr[1]) wen[1] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      p   = k % 2;
      lat = k / 2 + 1;
      if (reset_req) begin
        pq[k].delete();
      end else if (clken) begin
        if (pq[k].size() > 0 && int'(pq[k][0].age) == lat - 1) void'(pq[k].pop_front());
        for (int i = 0; i < pq[k].size(); i++) pq[k][i].age = pq[k][i].age + 8'd1;
        if (racc[p]) begin
          key     = int'(addr[p]);
          e.known = ref_mem.exists(key);
          e.data  = e.known ? ref_mem[key] : 32'h0;
          e.age   = 8'd0;
          pq[k].push_back(e);
        end
      end
    end
    for (int i = 0; i < 2; i++) if (wen[i]) mem_write(addr[i], be[i], wd[i]);
    if (LockEn && clken && lock_set) m_locked = 1'b1;
  endtask

  always @(posedge clk) begin
    if (!reset_n) begin
      for (int k = 0; k < 4; k++) pq[k].delete();
      m_locked = 1'b0;
    end else begin
      model_edge();
    end
  end

  always @(negedge clk) begin : p_cmp
    logic wt;
    logic ev;
    int   k;
    if (reset_n) begin
      wt = !clken || reset_req;
      for (int d = 0; d < 2; d++) begin
        for (int p = 0; p < 2; p++) begin
          k  = d * 2 + p;
          ev = !wt && pq[k].size() > 0 && int'(pq[k][0].age) == d;
          check($sformatf("d%0d s%0d waitrequest", d, p + 1), 64'(o_wt[d][p]), 64'(wt));
          check($sformatf("d%0d s%0d readdatavalid", d, p + 1), 64'(o_v[d][p]), 64'(ev));
          if (ev && pq[k][0].known) begin
            check($sformatf("d%0d s%0d readdata", d, p + 1), 64'(o_d[d][p]),
                  64'(pq[k][0].data));
          end
          if (o_v[d][p]) begin
            vcnt[d][p]++;
            last_d[d][p] = o_d[d][p];
            if (!clken) vlow++;
            if (burst_log && d == 1 && p == 0) burst_q.push_back(o_d[1][0]);
          end
        end
        check($sformatf("d%0d locked", d), 64'(o_lk[d]), 64'(m_locked));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cs       = '0;
    rd       = '0;
    wr       = '0;
    lock_set = 1'b0;
  endtask

  task automatic wr_op(input int p, input logic [Aw-1:0] a, input logic [3:0] b,
                       input logic [31:0] d);
    cs[p]   = 1'b1;
    wr[p]   = 1'b1;
    addr[p] = a;
    be[p]   = b;
    wd[p]   = d;
  endtask

  task automatic rd_op(input int p, input logic [Aw-1:0] a);
    cs[p]   = 1'b1;
    rd[p]   = 1'b1;
    addr[p] = a;
  endtask

  task automatic read_check(input int p, input logic [Aw-1:0] a, input logic [31:0] e,
                            input string nm);
    int c0 [2];
    for (int d = 0; d < 2; d++) c0[d] = vcnt[d][p];
    rd_op(p, a);
    tick();
    repeat (3) tick();
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s d%0d count", nm, d), 64'(vcnt[d][p] - c0[d]), 64'd1);
      check($sformatf("%s d%0d data", nm, d), 64'(last_d[d][p]), 64'(e));
    end
  endtask

  function automatic logic [31:0] init_val(input int i);
    return (i == 1) ? 32'h0 : (32'hC0DE_0000 | 32'(i));
  endfunction

  initial begin
    int c0 [2][2];
    int i, cyc;
    bit accepted;
    for (int p = 0; p < 2; p++) begin
      addr[p] = '0;
      be[p]   = '0;
      wd[p]   = '0;
      for (int d = 0; d < 2; d++) begin
        vcnt[d][p]   = 0;
        last_d[d][p] = '0;
      end
    end

    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("reset d%0d s1 valid", d), 64'(o_v[d][0]), 64'd0);
      check($sformatf("reset d%0d s2 valid", d), 64'(o_v[d][1]), 64'd0);
      check($sformatf("reset d%0d s1 data", d), 64'(o_d[d][0]), 64'd0);
      check($sformatf("reset d%0d locked", d), 64'(o_lk[d]), 64'd0);
    end
    reset_n = 1'b1;

    for (int a = 0; a < 8; a++) begin
      wr_op(0, Aw'(a), 4'hF, init_val(a));
      tick();
    end
    wr_op(0, 11'h7FF, 4'hF, 32'h0);
    tick();
    wr_op(0, 11'h020, 4'hF, 32'h0);
    tick();

    wr_op(0, 11'h010, 4'hF, 32'hDEAD_BEEF);
    tick();
    read_check(0, 11'h010, 32'hDEAD_BEEF, "s1 read 0x010");

    wr_op(1, 11'h7FF, 4'b0101, 32'h1122_3344);
    tick();
    read_check(1, 11'h7FF, 32'h0022_0044, "s2 byteenable");

    wr_op(0, 11'h020, 4'hF, 32'hAAAA_AAAA);
    wr_op(1, 11'h020, 4'hF, 32'h5555_5555);
    tick();
    read_check(0, 11'h020, 32'hAAAA_AAAA, "dual write");

    // Read on s1 while s2 overwrites the same word: old data expected.
    for (int d = 0; d < 2; d++) c0[d][0] = vcnt[d][0];
    rd_op(0, 11'h020);
    wr_op(1, 11'h020, 4'hF, 32'h1234_5678);
    tick();
    repeat (3) tick();
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rdw d%0d count", d), 64'(vcnt[d][0] - c0[d][0]), 64'd1);
      check($sformatf("rdw d%0d old data", d), 64'(last_d[d][0]), 64'h0000_0000_AAAA_AAAA);
    end
    read_check(1, 11'h020, 32'h1234_5678, "rdw new data");

    for (int d = 0; d < 2; d++) c0[d][0] = vcnt[d][0];
    rd_op(0, 11'h030);
    wr_op(0, 11'h030, 4'hF, 32'h0000_0007);
    tick();
    repeat (3) tick();
    for (int d = 0; d < 2; d++) begin
      check($sformatf("same-port rw d%0d no valid", d), 64'(vcnt[d][0] - c0[d][0]), 64'd0);
    end
    read_check(0, 11'h030, 32'h0000_0007, "same-port rw data");

    // Burst of 8 reads with clken low for 3 cycles in the middle.
    for (int d = 0; d < 2; d++) c0[d][0] = vcnt[d][0];
    vlow      = 0;
    burst_q.delete();
    burst_log = 1'b1;
    i         = 0;
    cyc       = 0;
    while (i < 8 && cyc < 40) begin
      clken    = !(cyc >= 3 && cyc <= 5);
      rd_op(0, Aw'(i));
      accepted = clken && !reset_req;
      tick();
      cyc++;
      if (accepted) i++;
    end
    clken = 1'b1;
    repeat (4) tick();
    burst_log = 1'b0;
    check("burst issued", 64'(i), 64'd8);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("burst d%0d count", d), 64'(vcnt[d][0] - c0[d][0]), 64'd8);
    end
    check("burst valid while clken low", 64'(vlow), 64'd0);
    check("burst order length", 64'(burst_q.size()), 64'd8);
    for (int k = 0; k < 8 && k < burst_q.size(); k++) begin
      check($sformatf("burst order %0d", k), 64'(burst_q[k]), 64'(init_val(k)));
    end

    // Flush an in-flight read with a one-cycle reset_req.
    for (int d = 0; d < 2; d++) for (int p = 0; p < 2; p++) c0[d][p] = vcnt[d][p];
    rd_op(0, 11'h002);
    tick();
    reset_req = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("flush d%0d s1 waitrequest", d), 64'(o_wt[d][0]), 64'd1);
      check($sformatf("flush d%0d s2 waitrequest", d), 64'(o_wt[d][1]), 64'd1);
    end
    @(posedge clk);
    #1;
    reset_req = 1'b0;
    repeat (3) tick();
    for (int d = 0; d < 2; d++) begin
      check($sformatf("flush d%0d no valid", d), 64'(vcnt[d][0] - c0[d][0]), 64'd0);
    end

    lock_set = 1'b1;
    tick();
    for (int d = 0; d < 2; d++) begin
      check($sformatf("lock d%0d locked", d), 64'(o_lk[d]), 64'(LockEn));
    end
    wr_op(0, 11'h001, 4'hF, 32'h0000_1234);
    tick();
    read_check(0, 11'h001, LockEn ? 32'h0 : 32'h0000_1234, "lock low write");
    wr_op(1, 11'h200, 4'hF, 32'h5A5A_5A5A);
    tick();
    read_check(1, 11'h200, 32'h5A5A_5A5A, "lock edge write");

    reset_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst d%0d locked", d), 64'(o_lk[d]), 64'd0);
      check($sformatf("rst d%0d valid", d), 64'(o_v[d][0]), 64'd0);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    read_check(0, 11'h200, 32'h5A5A_5A5A, "ram kept");
    wr_op(0, 11'h001, 4'hF, 32'h0000_BEEF);
    tick();
    read_check(1, 11'h001, 32'h0000_BEEF, "unlocked write");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
